// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file writeback widths and request type.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of writeback requests with simultaneous push/pop.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    push_i,
  input  logic    pop_i,
  input  wb_req_t din_i,
  output logic    full_o,
  output logic    empty_o,
  output logic [AW:0] count_o,
  output wb_req_t head_o
);
  wb_req_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign head_o = mem_q[rd_q];
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges pipeline and long-latency writebacks onto the register-file write port.
// Define REGFILE_WB_BYPASS_EN to let B requests skip an empty FIFO when A is idle.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_a_we,
  input  logic [4:0]  i_a_waddr,
  input  logic [31:0] i_a_wdata,
  input  logic        i_b_valid,
  output logic        o_b_ready,
  input  logic [4:0]  i_b_waddr,
  input  logic [31:0] i_b_wdata,
  input  logic        i_claim_valid,
  input  logic [4:0]  i_claim_addr,
  output logic        o_we,
  output logic [4:0]  o_waddr,
  output logic [31:0] o_wdata,
  output logic [31:0] o_busy,
  output logic        o_stall_req,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
  output logic        o_err
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  wb_req_t head, a_req, b_req, wb_d, wb_q;
  logic a_act, b_hs, bypass, push, drain, full, empty, we_d, we_q, stall_q, err_q;
  logic [31:0] busy_q, busy_d;
  logic [SW-1:0] starve_q, starve_d;
  assign a_req = '{addr: i_a_waddr, data: i_a_wdata};
  assign b_req = '{addr: i_b_waddr, data: i_b_wdata};
  assign o_b_ready = !full && !i_rst;
  assign a_act = i_a_we && i_a_waddr != REG_ZERO;
  assign b_hs = i_b_valid && o_b_ready && i_b_waddr != REG_ZERO;
  assign drain = !empty && (stall_q || !a_act);
`ifdef REGFILE_WB_BYPASS_EN
  assign bypass = b_hs && empty && !a_act && !stall_q;
`else
  assign bypass = 1'b0;
`endif
  assign push = b_hs && !bypass;
  assign o_we = we_q;
  assign o_waddr = wb_q.addr;
  assign o_wdata = wb_q.data;
  assign o_busy = busy_q;
  assign o_stall_req = stall_q;
  assign o_err = err_q;
  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(i_clk),
    .rst_i(i_rst),
    .push_i(push),
    .pop_i(drain),
    .din_i(b_req),
    .full_o(full),
    .empty_o(empty),
    .count_o(o_fifo_count),
    .head_o(head)
  );
  always_comb begin
    we_d = drain || a_act || bypass;
    wb_d = drain ? head : a_act ? a_req : b_req;
    starve_d = (empty || drain) ? '0 : starve_q + SW'(1);
    busy_d = busy_q;
    if (drain) busy_d[head.addr] = 1'b0;
    if (bypass) busy_d[i_b_waddr] = 1'b0;
    if (i_claim_valid && i_claim_addr != REG_ZERO) busy_d[i_claim_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end
  // An A write while stalled is dropped in favour of the head and flagged.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      we_q <= 1'b0;
      wb_q <= '0;
      busy_q <= '0;
      starve_q <= '0;
      stall_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      we_q <= we_d;
      if (we_d) wb_q <= wb_d;
      busy_q <= busy_d;
      starve_q <= starve_d;
      stall_q <= starve_d >= SW'(STARVE_LIMIT);
      err_q <= err_q || (a_act && stall_q);
    end
  end
endmodule
